bus_strobe_driver: RTL and testbench
====================================

Name: bus_strobe_driver

Overview:
- Parametrised successor to the backplane state driver.
- Watches a STATE_W-bit state word. On any change it waits for the word to settle, then drives a registered copy onto the backplane bus and holds a strobe (enable) high for a fixed time.
- Adds four things the earlier driver lacked: a guaranteed minimum low gap between strobes, a bus word frozen while the strobe is high, a queued (pending) change, and a software resend request.
- Sits between the master sequencer and the CapBoardDecoder backplane.

Parameters:
- STATE_W, 7: width of the state word and of the bus.
- SETTLE_CYCLES, 8: number of stable cycles required before the strobe asserts (>=1).
- ENABLE_ON_CYCLES, 32: number of cycles enable stays high (>=1).
- GAP_CYCLES, 4: minimum number of cycles enable stays low between strobes (>=0).
- CNT_W, 16: width of pulse_count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- state_in  in  STATE_W  requested state from the sequencer.
- resend_req  in  1  single-cycle request to re-strobe the current state.
- bus_state  out  STATE_W  registered word driven onto the backplane bus.
- enable  out  1  strobe to the listener boards; registered.
- busy  out  1  high when FSM != IDLE or pending=1.
- pulse_count  out  CNT_W  count of completed strobes; wraps.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release) clears these immediately:
  - outputs: bus_state=0, enable=0, busy=0, pulse_count=0;
  - internals: state_last=0, pending=0, cnt=0, FSM=IDLE.
- change = (state_in != state_last) | resend_req. On every change, state_last <= state_in in all states; the last value wins and intermediate values collapse.
- One shared counter cnt, wide enough for max(SETTLE_CYCLES, ENABLE_ON_CYCLES, GAP_CYCLES).
- FSM:
  - IDLE: on change -> SETTLE, cnt=0.
  - SETTLE: on change -> cnt=0 (restart). Otherwise, if cnt==SETTLE_CYCLES-1: bus_state<=state_last, enable<=1, pending<=0, cnt=0 -> ENABLE. Otherwise cnt++.
  - ENABLE: on change -> pending<=1; bus_state does not change. If cnt==ENABLE_ON_CYCLES-1: enable<=0, pulse_count++, cnt=0 -> GAP (or -> IDLE/SETTLE directly if GAP_CYCLES==0, with the same pending rule as GAP exit). Otherwise cnt++.
  - GAP: on change -> pending<=1. If cnt==GAP_CYCLES-1: if pending (or change this cycle) -> SETTLE with cnt=0 and pending<=0; otherwise -> IDLE. Otherwise cnt++.
- Latency: change detected at edge T with state_in stable afterwards -> enable high from edge T+SETTLE_CYCLES for exactly ENABLE_ON_CYCLES cycles.
- Between strobes, enable is low for at least GAP_CYCLES+SETTLE_CYCLES cycles.
- bus_state changes only on SETTLE->ENABLE, and therefore never while enable=1.
- A change back to the value currently on bus_state still produces a strobe.
- pulse_count wraps from all-ones to 0 with no flag.
- resend_req is treated as a change even when state_in==state_last.
- Reset mid-operation: outputs clear at once, with no completing pulse. After release, a nonzero state_in differs from state_last=0 and therefore starts a new strobe.

Decomposition:
- bus_strobe_pkg holds:
  - FSM state enum {IDLE, SETTLE, ENABLE, GAP};
  - a counter-width function, clog2 of the maximum phase length;
  - default timing constants.
- One sub-module, cycle_timer: a loadable up-counter with a terminal-count compare, reused by all three timed phases.

Test Plan:
- Reset, then state_in 0->0x15 at edge 10, held -> enable=1 on edges 18..49, bus_state=0x15 from edge 18, pulse_count=1 at edge 50, busy=0 from edge 54.
- Bouncing input: 0x01@10, 0x02@13, 0x2A@15, then stable -> exactly one strobe, enable high 23..54, bus_state=0x2A, pulse_count=1.
- 0x15@10, then 0x33@30 during ENABLE -> bus_state stays 0x15 through edge 49; enable low 50..61; SETTLE from edge 54; enable high 62..93 with bus_state=0x33; pulse_count=2.
- rst_n low at edge 30 during ENABLE, state_in=0x15 held -> enable, bus_state and pulse_count go to 0 with no clock edge. Release at edge 35 -> new strobe, enable high from edge 43.
- In IDLE, resend_req pulse at edge 100 with state unchanged 0x15 -> enable high 108..139, bus_state=0x15, pulse_count incremented.
- Build with GAP_CYCLES=0, ENABLE_ON_CYCLES=2, SETTLE_CYCLES=1, CNT_W=2; drive 5 toggled changes spaced 10 cycles apart -> pulse_count sequence 1,2,3,0,1 (wrap) and enable never high for more than 2 consecutive cycles.

Source files
------------

// File: rtl/bus_strobe_pkg.sv
// ============================================================================
// Module   : bus_strobe_pkg
// Purpose  : Shared FSM encoding, default timing and counter sizing for the
//            backplane bus strobe driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bus_strobe_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ENABLE = 2'd2,
      GAP    = 2'd3
   } strobeState_t;

   localparam int c_DEF_STATE_W    = 7;
   localparam int c_DEF_SETTLE     = 8;
   localparam int c_DEF_ENABLE_ON  = 32;
   localparam int c_DEF_GAP        = 4;
   localparam int c_DEF_CNT_W      = 16;

   // Phase counters run 0..len-1, so clog2 of the longest phase is enough.
   function automatic int cntWidth(input int a, input int b, input int c);
      int m;
      int w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      w = 1;
      while ((1 << w) < m) w++;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
// ============================================================================
// Module   : cycle_timer
// Purpose  : Clearable up-counter with a terminal-count compare shared by all
//            timed phases of the strobe driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cycle_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             advance,
   input  logic [WIDTH-1:0] limit,
   output logic             done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (advance) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign done = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/bus_strobe_driver.sv
// ============================================================================
// Module   : bus_strobe_driver
// Purpose  : Debounces a state word, then drives it onto the backplane with a
//            fixed-length strobe, a minimum low gap and a queued change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_strobe_driver
   import bus_strobe_pkg::*;
#(
   parameter int STATE_W          = c_DEF_STATE_W,
   parameter int SETTLE_CYCLES    = c_DEF_SETTLE,
   parameter int ENABLE_ON_CYCLES = c_DEF_ENABLE_ON,
   parameter int GAP_CYCLES       = c_DEF_GAP,
   parameter int CNT_W            = c_DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STATE_W-1:0] state_in,
   input  logic               resend_req,
   output logic [STATE_W-1:0] bus_state,
   output logic               enable,
   output logic               busy,
   output logic [CNT_W-1:0]   pulse_count
);

   localparam int c_TW = cntWidth(SETTLE_CYCLES, ENABLE_ON_CYCLES, GAP_CYCLES);
   localparam logic [c_TW-1:0] c_SETTLE_LIM = c_TW'(SETTLE_CYCLES - 1);
   localparam logic [c_TW-1:0] c_ENABLE_LIM = c_TW'(ENABLE_ON_CYCLES - 1);
   localparam logic [c_TW-1:0] c_GAP_LIM    = c_TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   strobeState_t        r_state;
   logic [STATE_W-1:0]  r_stateLast;
   logic [STATE_W-1:0]  r_busState;
   logic                r_pending;
   logic                r_enable;
   logic [CNT_W-1:0]    r_pulseCount;

   logic                w_change;
   logic                w_atLimit;
   logic                w_clear;
   logic                w_advance;
   logic [c_TW-1:0]     w_limit;

   assign w_change = (state_in != r_stateLast) | resend_req;

   always_comb begin
      w_clear   = 1'b0;
      w_advance = 1'b0;
      w_limit   = c_SETTLE_LIM;
      case (r_state)
         IDLE: begin
            w_clear = 1'b1;
         end
         SETTLE: begin
            w_limit   = c_SETTLE_LIM;
            w_clear   = w_change | w_atLimit;
            w_advance = ~w_clear;
         end
         ENABLE: begin
            w_limit   = c_ENABLE_LIM;
            w_clear   = w_atLimit;
            w_advance = ~w_atLimit;
         end
         GAP: begin
            w_limit   = c_GAP_LIM;
            w_clear   = w_atLimit;
            w_advance = ~w_atLimit;
         end
         default: w_clear = 1'b1;
      endcase
   end

   cycle_timer #(
      .WIDTH (c_TW)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_clear),
      .advance (w_advance),
      .limit   (w_limit),
      .done    (w_atLimit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_stateLast  <= '0;
         r_busState   <= '0;
         r_pending    <= 1'b0;
         r_enable     <= 1'b0;
         r_pulseCount <= '0;
      end else begin
         if (w_change) r_stateLast <= state_in;
         case (r_state)
            IDLE: begin
               if (w_change) r_state <= SETTLE;
            end
            SETTLE: begin
               if (!w_change && w_atLimit) begin
                  r_busState <= r_stateLast;
                  r_enable   <= 1'b1;
                  r_pending  <= 1'b0;
                  r_state    <= ENABLE;
               end
            end
            ENABLE: begin
               if (w_change) r_pending <= 1'b1;
               if (w_atLimit) begin
                  r_enable     <= 1'b0;
                  r_pulseCount <= r_pulseCount + 1'b1;
                  if (GAP_CYCLES != 0) begin
                     r_state <= GAP;
                  end else if (r_pending || w_change) begin
                     r_state   <= SETTLE;
                     r_pending <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (w_change) r_pending <= 1'b1;
               if (w_atLimit) begin
                  if (r_pending || w_change) begin
                     r_state   <= SETTLE;
                     r_pending <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus_state   = r_busState;
   assign enable      = r_enable;
   assign pulse_count = r_pulseCount;
   assign busy        = (r_state != IDLE) | r_pending;

endmodule

`default_nettype wire

// File: tb/tb_bus_strobe_driver.sv
// ============================================================================
// Module   : tb_bus_strobe_driver
// Purpose  : Directed self-checking bench for bus_strobe_driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_strobe_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  stateIn = '0;
   logic        resend = 1'b0;
   logic [6:0]  busState;
   logic        en;
   logic        busy;
   logic [15:0] pulseCount;

   logic [6:0]  stateW = '0;
   logic        resendW = 1'b0;
   logic [6:0]  busStateW;
   logic        enW;
   logic        busyW;
   logic [1:0]  pulseCountW;

   int tests = 0;
   int failed = 0;
   int edgeNow = 0;
   int runLen = 0;
   int maxRun = 0;

   always #5 clk = ~clk;

   bus_strobe_driver dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .state_in    (stateIn),
      .resend_req  (resend),
      .bus_state   (busState),
      .enable      (en),
      .busy        (busy),
      .pulse_count (pulseCount)
   );

   bus_strobe_driver #(
      .STATE_W          (7),
      .SETTLE_CYCLES    (1),
      .ENABLE_ON_CYCLES (2),
      .GAP_CYCLES       (0),
      .CNT_W            (2)
   ) dutW (
      .clk         (clk),
      .rst_n       (rst_n),
      .state_in    (stateW),
      .resend_req  (resendW),
      .bus_state   (busStateW),
      .enable      (enW),
      .busy        (busyW),
      .pulse_count (pulseCountW)
   );

   always @(negedge clk) begin
      runLen = enW ? runLen + 1 : 0;
      if (runLen > maxRun) maxRun = runLen;
   end

   typedef struct {
      int          edgeN;
      logic [6:0]  stateIn;
      logic        resend;
      logic        expEn;
      logic [6:0]  expBus;
      logic [15:0] expCnt;
      logic        expBusy;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", name, edgeNow, act, exp);
      end
   endtask

   // Edge 0 is the first rising edge after release.
   task automatic doReset();
      rst_n   = 1'b0;
      stateIn = '0;
      resend  = 1'b0;
      stateW  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      edgeNow = -1;
   endtask

   task automatic stepTo(input int e);
      repeat (e - edgeNow) @(posedge clk);
      #1;
      edgeNow = e;
   endtask

   initial begin
      tbl[0]  = '{0,   7'h00, 1'b0, 1'b0, 7'h00, 16'd0, 1'b0};
      tbl[1]  = '{9,   7'h15, 1'b0, 1'b0, 7'h00, 16'd0, 1'b0};
      tbl[2]  = '{10,  7'h15, 1'b0, 1'b0, 7'h00, 16'd0, 1'b1};
      tbl[3]  = '{17,  7'h15, 1'b0, 1'b0, 7'h00, 16'd0, 1'b1};
      tbl[4]  = '{18,  7'h15, 1'b0, 1'b1, 7'h15, 16'd0, 1'b1};
      tbl[5]  = '{49,  7'h15, 1'b0, 1'b1, 7'h15, 16'd0, 1'b1};
      tbl[6]  = '{50,  7'h15, 1'b0, 1'b0, 7'h15, 16'd1, 1'b1};
      tbl[7]  = '{53,  7'h15, 1'b0, 1'b0, 7'h15, 16'd1, 1'b1};
      tbl[8]  = '{54,  7'h15, 1'b0, 1'b0, 7'h15, 16'd1, 1'b0};
      tbl[9]  = '{99,  7'h15, 1'b1, 1'b0, 7'h15, 16'd1, 1'b0};
      tbl[10] = '{100, 7'h15, 1'b0, 1'b0, 7'h15, 16'd1, 1'b1};
      tbl[11] = '{107, 7'h15, 1'b0, 1'b0, 7'h15, 16'd1, 1'b1};
      tbl[12] = '{108, 7'h15, 1'b0, 1'b1, 7'h15, 16'd1, 1'b1};
      tbl[13] = '{139, 7'h15, 1'b0, 1'b1, 7'h15, 16'd1, 1'b1};
      tbl[14] = '{140, 7'h15, 1'b0, 1'b0, 7'h15, 16'd2, 1'b1};
      tbl[15] = '{144, 7'h15, 1'b0, 1'b0, 7'h15, 16'd2, 1'b0};

      // Basic strobe plus a resend from IDLE.
      doReset();
      for (int i = 0; i < 16; i++) begin
         stepTo(tbl[i].edgeN);
         check("tblEnable", {31'd0, en}, {31'd0, tbl[i].expEn});
         check("tblBus", {25'd0, busState}, {25'd0, tbl[i].expBus});
         check("tblCount", {16'd0, pulseCount}, {16'd0, tbl[i].expCnt});
         check("tblBusy", {31'd0, busy}, {31'd0, tbl[i].expBusy});
         stateIn = tbl[i].stateIn;
         resend  = tbl[i].resend;
      end

      // Bouncing input collapses into one strobe of the final value.
      doReset();
      stepTo(9);  stateIn = 7'h01;
      stepTo(12); stateIn = 7'h02;
      stepTo(14); stateIn = 7'h2A;
      stepTo(22); check("bounceEnLow", {31'd0, en}, 32'd0);
      stepTo(23); check("bounceEnHigh", {31'd0, en}, 32'd1);
                  check("bounceBus", {25'd0, busState}, 32'h2A);
      stepTo(54); check("bounceEnLast", {31'd0, en}, 32'd1);
      stepTo(55); check("bounceEnOff", {31'd0, en}, 32'd0);
      stepTo(80); check("bounceCount", {16'd0, pulseCount}, 32'd1);
                  check("bounceBusy", {31'd0, busy}, 32'd0);

      // Change during ENABLE is queued; bus word frozen meanwhile.
      doReset();
      stepTo(9);  stateIn = 7'h15;
      stepTo(29); stateIn = 7'h33;
      stepTo(30); check("pendBusFrozen", {25'd0, busState}, 32'h15);
      stepTo(49); check("pendBus49", {25'd0, busState}, 32'h15);
                  check("pendEn49", {31'd0, en}, 32'd1);
      stepTo(50); check("pendEn50", {31'd0, en}, 32'd0);
                  check("pendCnt50", {16'd0, pulseCount}, 32'd1);
      stepTo(54); check("pendBusy54", {31'd0, busy}, 32'd1);
      stepTo(61); check("pendEn61", {31'd0, en}, 32'd0);
                  check("pendBus61", {25'd0, busState}, 32'h15);
      stepTo(62); check("pendEn62", {31'd0, en}, 32'd1);
                  check("pendBus62", {25'd0, busState}, 32'h33);
      stepTo(93); check("pendEn93", {31'd0, en}, 32'd1);
      stepTo(94); check("pendEn94", {31'd0, en}, 32'd0);
                  check("pendCnt94", {16'd0, pulseCount}, 32'd2);

      // Asynchronous reset mid-strobe, then restart after release.
      doReset();
      stepTo(9);  stateIn = 7'h15;
      stepTo(29); check("rstPreEn", {31'd0, en}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstAsyncEn", {31'd0, en}, 32'd0);
      check("rstAsyncBus", {25'd0, busState}, 32'd0);
      check("rstAsyncCnt", {16'd0, pulseCount}, 32'd0);
      check("rstAsyncBusy", {31'd0, busy}, 32'd0);
      stepTo(34); rst_n = 1'b1;
      stepTo(42); check("rstRelEn42", {31'd0, en}, 32'd0);
                  check("rstRelBusy42", {31'd0, busy}, 32'd1);
      stepTo(43); check("rstRelEn43", {31'd0, en}, 32'd1);
                  check("rstRelBus43", {25'd0, busState}, 32'h15);

      // Zero-gap build: pulse_count wraps and strobes stay two cycles.
      doReset();
      for (int k = 0; k < 5; k++) begin
         stepTo(10 * k + 9);
         stateW = ~stateW;
         stepTo(10 * k + 11);
         check("wrapEnHigh", {31'd0, enW}, 32'd1);
         stepTo(10 * k + 13);
         check("wrapEnLow", {31'd0, enW}, 32'd0);
         check("wrapCount", {30'd0, pulseCountW}, (k + 1) % 4);
      end
      stepTo(70);
      check("wrapMaxRun", maxRun, 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
